// File: rtl/down_counter_pkg.sv
// Shared definitions for the down counter/timer: FSM state encoding and reload mode constants.
package down_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down counter/timer; master drives controls, slave is the counter.
interface down_counter_timer_if #(
    parameter int unsigned WIDTH = 4
);

    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             restart;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc_pulse;
    logic             busy;

    modport master (
        output load, load_value, restart, enable, auto_reload,
        input  count, zero, tc_pulse, busy
    );

    modport slave (
        input  load, load_value, restart, enable, auto_reload,
        output count, zero, tc_pulse, busy
    );

endinterface

// File: rtl/down_counter_prescaler.sv
// Enable-tick prescaler: emits one count step every PRESCALE enabled cycles while running.
module down_counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic clr,
    input  logic run,
    input  logic enable,
    output logic step
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    assign step = run && enable && (pre_q == LAST);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pre_q <= '0;
        end else if (clr) begin
            pre_q <= '0;
        end else if (run && enable) begin
            pre_q <= (pre_q == LAST) ? '0 : pre_q + 1'b1;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down counter/timer with terminal-count pulse and one-shot/auto-reload modes.
// Define DOWN_COUNTER_PRESCALE_EN to divide enable by PRESCALE before each count step.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input logic                 clock,
    input logic                 clear_n,
    down_counter_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_pulse_q;
    logic             step;

`ifdef DOWN_COUNTER_PRESCALE_EN
    down_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .clear_n (clear_n),
        .clr     (bus.load | bus.restart),
        .run     (state_q == ST_RUN),
        .enable  (bus.enable),
        .step    (step)
    );
`else
    // PRESCALE only matters with the prescaler built in; keep it referenced.
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign step = bus.enable;
`endif

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            tc_pulse_q <= 1'b0;
        end else begin
            tc_pulse_q <= 1'b0;
            if (bus.load) begin
                reload_q <= bus.load_value;
                count_q  <= bus.load_value;
                state_q  <= (bus.load_value != '0) ? ST_RUN : ST_IDLE;
            end else if (bus.restart) begin
                count_q <= reload_q;
                state_q <= (reload_q != '0) ? ST_RUN : ST_IDLE;
            end else if (state_q == ST_RUN && step) begin
                if (count_q > ONE) begin
                    count_q <= count_q - ONE;
                end else begin
                    // Terminal step: pulse coincides with the reload or the drop to zero.
                    tc_pulse_q <= 1'b1;
                    if (bus.auto_reload == MODE_AUTO) begin
                        count_q <= reload_q;
                    end else begin
                        count_q <= '0;
                        state_q <= ST_EXPIRED;
                    end
                end
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.zero     = (count_q == '0);
    assign bus.tc_pulse = tc_pulse_q;
    assign bus.busy     = (state_q == ST_RUN);

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, programmable down counter/timer: the count-down counterpart to the team's 4-bit up counter.
- Counts from a loaded value toward zero on enabled clock edges.
- Flags terminal count with a one-cycle pulse; supports one-shot and auto-reload modes.
- Used as the delay/period generator beside the up-counter blocks in lab datapaths.

Parameters:
- WIDTH, 4, counter and load-value width in bits (>= 2).
- PRESCALE, 4, enable ticks per count step; used only when the optional feature is compiled in (>= 2).

Ports:
- clock  input  1  system clock; all state updates on the positive edge.
- clear_n  input  1  asynchronous active-low reset.
- load  input  1  load load_value into the count and reload registers.
- load_value  input  WIDTH  value to load.
- restart  input  1  re-arm from the reload register without a new load_value.
- enable  input  1  count-step qualifier.
- auto_reload  input  1  0 = one-shot, 1 = periodic; sampled at the terminal step.
- count  output  WIDTH  current count (registered).
- zero  output  1  high when count == 0.
- tc_pulse  output  1  one-cycle terminal-count pulse (registered).
- busy  output  1  high in state RUN.

Behaviour:
- Reset (clear_n low, asynchronous; release is synchronous to clock):
  - count = 0, reload_reg = 0, state = IDLE, tc_pulse = 0, busy = 0, zero = 1.
- States: IDLE (never armed or loaded with 0), RUN (counting), EXPIRED (one-shot finished).
- step = enable (without feature) or prescaler terminal tick (with feature).
- Priority each edge: load > restart > step.
- load:
  - reload_reg <= load_value, count <= load_value.
  - load_value != 0 -> RUN. load_value == 0 -> IDLE, no tc_pulse.
  - Accepted in any state, including mid-count; aborts current count, no tc_pulse for the aborted period.
- restart:
  - count <= reload_reg.
  - RUN if reload_reg != 0, else IDLE. Accepted in any state.
- RUN, step, count > 1: count <= count - 1.
- RUN, step, count == 1: tc_pulse <= 1 for exactly one cycle, coincident with the terminal update:
  - auto_reload = 0: count <= 0, state -> EXPIRED.
  - auto_reload = 1: count <= reload_reg, stay RUN. Period = reload_reg steps; count never shows 0.
- IDLE/EXPIRED: step ignored; count holds. No wrap from 0 to 2^WIDTH-1.
- tc_pulse low in every cycle not listed above.
- Latency: load/restart at edge N -> count valid after edge N; busy follows state, same edge.
- Arithmetic: unsigned, WIDTH bits; decrement never issued at 0.
- Max value 2^WIDTH-1 loads and counts normally.
- Reset mid-RUN: immediate return to reset values; any in-flight tc_pulse is dropped.

Optional Feature:
- Macro: DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - A prescaler counter (width ceil(log2(PRESCALE))) increments on enable while in RUN.
  - step asserts when the prescaler reaches PRESCALE-1 with enable high; prescaler then wraps to 0.
  - Prescaler clears on reset, load and restart, and holds outside RUN.
- Not defined:
  - step = enable; PRESCALE unused; no prescaler flops.

Decomposition:
- Shared package down_counter_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_EXPIRED = 2'd2.
  - mode constants MODE_ONESHOT = 1'b0, MODE_AUTO = 1'b1.
- One sub-module: down_counter_prescaler, containing the prescaler, instantiated only under DOWN_COUNTER_PRESCALE_EN. Top holds the FSM, count, reload and pulse logic.

Test Plan:
- Reset: clear_n low mid-RUN with count = 7 -> count 0, zero 1, busy 0, tc_pulse 0 immediately, without a clock edge.
- One-shot: load 5, auto_reload 0, enable held -> count 5,4,3,2,1,0; tc_pulse high only in the cycle count becomes 0; state EXPIRED; further enable keeps count 0.
- Auto-reload: load 3, auto_reload 1, enable held -> count 3,2,1,3,2,1,...; tc_pulse every 3rd cycle, on each 1->3 transition; busy stays 1.
- Priority/abort: load 9, 4 steps (count 5); then load and restart together with load_value 2 -> count 2 (load wins), no tc_pulse. restart alone later -> count 2, RUN.
- Boundaries:
  - load 0 -> IDLE, zero 1, no tc_pulse, enable ignored.
  - load 15 (WIDTH 4) -> 15 steps to tc_pulse; no wrap.
  - enable toggling -> count changes only on enabled edges.
- With DOWN_COUNTER_PRESCALE_EN, PRESCALE 4: load 2, enable held -> count decrements every 4th edge; tc_pulse at edge 8 after load.
